// File: rtl/store_merge_unit.sv
// Store-path unit: narrows a register value to SB/SH/SW width and writes it to a word-addressed
// memory, doing a read-modify-write over a ready handshake for sub-word stores.
module store_merge_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] OpSb = 2'b00;
    localparam logic [1:0] OpSh = 2'b01;
    localparam logic [1:0] OpSw = 2'b10;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q;
    logic              half_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              misalign_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              fault;
    logic [31:0]       merged;

    always_comb begin
        fault = 1'b0;
        case (op)
            OpSb:    fault = 1'b0;
            OpSh:    fault = addr[0];
            OpSw:    fault = |addr[1:0];
            default: fault = 1'b1;
        endcase
    end

    // Little-endian lane replacement on the word just read back.
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            if (lane_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end else begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            half_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0000;
            misalign_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                StIdle: begin
                    misalign_q <= 1'b0;
                    if (start) begin
                        half_q      <= op[0];
                        lane_q      <= addr[1:0];
                        wdata_q     <= wdata[15:0];
                        mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= wdata;
                        if (fault) begin
                            misalign_q <= 1'b1;
                            state_q    <= StDone;
                        end else if (op == OpSw) begin
                            state_q <= StWr;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (mem_ready) begin
                        mem_wdata_q <= merged;
                        state_q     <= StWr;
                    end
                end
                StWr: begin
                    if (mem_ready) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    misalign_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign mem_rd    = (state_q == StRd);
    assign mem_wr    = (state_q == StWr);
    assign misalign  = misalign_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed cases plus randomized stores checked
// against a byte-lane memory model.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [int];

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic is_fault(input logic [1:0] o, input logic [31:0] a);
        return (o == 2'd3) || (o == 2'd1 && (a % 2) != 0) || (o == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [31:0] old);
        int sh;
        if (o == 2'd0) begin
            sh = 8 * int'(a % 4);
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (o == 2'd1) begin
            sh = 16 * int'((a / 2) % 2);
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    // Drives one store and plays the memory side; observations are taken on the falling edge.
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          input logic [31:0] t_rdata, input int rd_waits, input int wr_waits,
                          input int poke_at, output int lat, output logic mis, output int rd_n,
                          output int wr_n, output logic [31:0] rd_addr, output logic [31:0] wr_addr,
                          output logic [31:0] wr_data, output int bad, output logic idle0,
                          output logic busy1);
        @(negedge clk);
        idle0 = !busy;
        start = 1'b1; op = t_op; addr = t_addr; wdata = t_wdata; mem_ready = 1'b0;
        lat = 0; mis = 1'b0; rd_n = 0; wr_n = 0; bad = 0; busy1 = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == poke_at);
            if (start) begin
                op = 2'd2; addr = t_addr ^ 32'h100; wdata = ~t_wdata;
            end
            if (c == 1) busy1 = busy;
            if (mem_rd && mem_wr) bad++;
            if (misalign && !done) bad++;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (mem_rd) begin
                rd_n++;
                rd_addr = mem_addr;
                mem_ready = (rd_n > rd_waits);
                if (mem_ready) mem_rdata = t_rdata;
            end else if (mem_wr) begin
                if (wr_n > 0 && (mem_wdata !== wr_data || mem_addr !== wr_addr)) bad++;
                wr_n++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
                mem_ready = (wr_n > wr_waits);
            end
            if (done) begin
                lat = c;
                mis = misalign;
                mem_ready = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'd0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, misalign, mem_rd, mem_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, misalign, mem_rd, mem_wr});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data got addr %h data %h want 0 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw();
        int lat, rd_n, wr_n, bad; logic mis, idle0, busy1; logic [31:0] ra, wa, wd;
        run_op(2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad, idle0, busy1);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sw_busy got %b want 1", busy1); end
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
        checks++; if (rd_n != 0 || wr_n != 1) begin
            errors++; $display("FAIL sw_cycles got rd %0d wr %0d want rd 0 wr 1", rd_n, wr_n); end
        checks++; if (wa !== 32'h10 || wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_write got %h/%h want 00000010/deadbeef", wa, wd); end
        checks++; if (mis !== 1'b0 || bad != 0) begin
            errors++; $display("FAIL sw_misc got mis %b bad %0d want 0 0", mis, bad); end
    endtask

    task automatic test_sb();
        int lat, rd_n, wr_n, bad; logic mis, idle0, busy1; logic [31:0] ra, wa, wd;
        run_op(2'd0, 32'h23, 32'h000000AB, 32'h11223344, 0, 0, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad, idle0, busy1);
        checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
        checks++; if (rd_n != 1 || ra !== 32'h20) begin
            errors++; $display("FAIL sb_read got %0d@%h want 1@00000020", rd_n, ra); end
        checks++; if (wd !== 32'hAB223344 || wa !== 32'h20) begin
            errors++; $display("FAIL sb_write got %h@%h want ab223344@00000020", wd, wa); end
        checks++; if (mis !== 1'b0 || bad != 0) begin
            errors++; $display("FAIL sb_misc got mis %b bad %0d want 0 0", mis, bad); end
    endtask

    task automatic test_sh_wait();
        int lat, rd_n, wr_n, bad; logic mis, idle0, busy1; logic [31:0] ra, wa, wd;
        run_op(2'd1, 32'h06, 32'hFFFFCAFE, 32'h11223344, 2, 1, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad, idle0, busy1);
        checks++; if (lat != 6) begin errors++; $display("FAIL sh_latency got %0d want 6", lat); end
        checks++; if (rd_n != 3 || wr_n != 2) begin
            errors++; $display("FAIL sh_cycles got rd %0d wr %0d want 3 2", rd_n, wr_n); end
        checks++; if (wd !== 32'hCAFE3344 || wa !== 32'h04) begin
            errors++; $display("FAIL sh_write got %h@%h want cafe3344@00000004", wd, wa); end
        checks++; if (bad != 0) begin errors++; $display("FAIL sh_protocol got %0d want 0", bad); end
    endtask

    task automatic test_faults();
        logic [1:0]  f_op [3];
        logic [31:0] f_ad [3];
        int lat, rd_n, wr_n, bad; logic mis, idle0, busy1; logic [31:0] ra, wa, wd;
        f_op[0] = 2'd1; f_ad[0] = 32'h01;
        f_op[1] = 2'd2; f_ad[1] = 32'h02;
        f_op[2] = 2'd3; f_ad[2] = 32'h08;
        for (int i = 0; i < 3; i++) begin
            run_op(f_op[i], f_ad[i], $urandom, $urandom, 0, 0, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad,
                   idle0, busy1);
            checks++; if (lat != 1 || mis !== 1'b1) begin
                errors++; $display("FAIL fault%0d_done got lat %0d mis %b want 1 1", i, lat, mis); end
            checks++; if (rd_n != 0 || wr_n != 0) begin
                errors++; $display("FAIL fault%0d_access got rd %0d wr %0d want 0 0", i, rd_n, wr_n); end
            @(negedge clk);
            checks++; if (busy !== 1'b0 || misalign !== 1'b0) begin
                errors++; $display("FAIL fault%0d_release got busy %b mis %b want 0 0", i, busy, misalign); end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; op = 2'd2; addr = 32'h40; wdata = 32'h12345678; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstmid_in_wr got %b want 1", mem_wr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, mem_wr, mem_rd, done} !== 4'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rstmid_idle got %b addr %h want 0000 0", {busy, mem_wr, mem_rd, done}, mem_addr);
        end
        mem_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || mem_wr || busy) seen++;
        end
        mem_ready = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_quiet got %0d want 0", seen); end
    endtask

    task automatic test_ignored_start();
        int lat, rd_n, wr_n, bad, seen; logic mis, idle0, busy1; logic [31:0] ra, wa, wd;
        run_op(2'd0, 32'h31, 32'h0000005A, 32'hCCCCCCCC, 2, 0, 2, lat, mis, rd_n, wr_n, ra, wa, wd, bad,
               idle0, busy1);
        checks++; if (lat != 5 || wd !== 32'hCCCC5ACC || wa !== 32'h30) begin
            errors++; $display("FAIL ignstart_first got %0d %h@%h want 5 cccc5acc@00000030", lat, wd, wa); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || mem_rd || mem_wr) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL ignstart_second got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  b_op [3];
        logic [31:0] b_ad [3];
        logic [31:0] b_wd [3];
        int lat, rd_n, wr_n, bad; logic mis, idle0, busy1; logic [31:0] ra, wa, wd, want;
        b_op[0] = 2'd2; b_ad[0] = 32'h80; b_wd[0] = 32'hA5A5A5A5;
        b_op[1] = 2'd0; b_ad[1] = 32'h81; b_wd[1] = 32'h00000077;
        b_op[2] = 2'd1; b_ad[2] = 32'h82; b_wd[2] = 32'h00001234;
        for (int i = 0; i < 3; i++) begin
            run_op(b_op[i], b_ad[i], b_wd[i], 32'h89ABCDEF, 0, 0, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad,
                   idle0, busy1);
            want = exp_word(b_op[i], b_ad[i], b_wd[i], 32'h89ABCDEF);
            checks++; if (i > 0 && idle0 !== 1'b1) begin
                errors++; $display("FAIL b2b%0d_idle got %b want 1", i, idle0); end
            checks++; if (lat != ((b_op[i] == 2'd2) ? 2 : 3) || wd !== want) begin
                errors++; $display("FAIL b2b%0d got lat %0d data %h want data %h", i, lat, wd, want); end
        end
    endtask

    task automatic test_random();
        int lat, rd_n, wr_n, bad, rw, ww, w, exp_lat; logic mis, idle0, busy1, f;
        logic [31:0] ra, wa, wd, a, d, old, want;
        logic [1:0] o;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            rw = $urandom_range(0, 2);
            ww = $urandom_range(0, 2);
            w = int'(a / 4);
            if (!mem_model.exists(w)) mem_model[w] = $urandom;
            old = mem_model[w];
            f = is_fault(o, a);
            run_op(o, a, d, old, rw, ww, 0, lat, mis, rd_n, wr_n, ra, wa, wd, bad, idle0, busy1);
            exp_lat = f ? 1 : (o == 2'd2) ? 2 + ww : 3 + rw + ww;
            checks++; if (lat != exp_lat || mis !== f) begin
                errors++; $display("FAIL rnd%0d_done got lat %0d mis %b want %0d %b", i, lat, mis, exp_lat, f); end
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_protocol got %0d want 0", i, bad); end
            if (f) begin
                checks++; if (rd_n != 0 || wr_n != 0) begin
                    errors++; $display("FAIL rnd%0d_fault_access got %0d %0d want 0 0", i, rd_n, wr_n); end
            end else begin
                want = exp_word(o, a, d, old);
                checks++; if (rd_n != ((o == 2'd2) ? 0 : rw + 1) || wr_n != ww + 1) begin
                    errors++; $display("FAIL rnd%0d_cycles got rd %0d wr %0d", i, rd_n, wr_n); end
                checks++; if (wd !== want || wa !== 32'(w * 4)) begin
                    errors++; $display("FAIL rnd%0d_write got %h@%h want %h@%h", i, wd, wa, want, 32'(w * 4)); end
                if (o != 2'd2) begin
                    checks++; if (ra !== 32'(w * 4)) begin
                        errors++; $display("FAIL rnd%0d_rdaddr got %h want %h", i, ra, 32'(w * 4)); end
                end
                mem_model[w] = want;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_sh_wait();
        test_faults();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Multi-cycle store-path unit for the non-pipelined MIPS datapath, the write-side counterpart of load sign extension. It takes a 32-bit register value and narrows it into byte (SB), halfword (SH) or word (SW) width. For sub-word stores it performs a read-modify-write against a word-addressed data memory over a ready-based handshake. It sits between the register-file read port / ALU address output and the data memory, and reports completion and alignment faults to the control FSM.

## Interface
- `ADDR_W`, default 32: byte-address width; `mem_addr` has the same width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled only in IDLE.
- `op` input 2: store type. 00 = SB, 01 = SH, 10 = SW, 11 = reserved (treated as a fault).
- `addr` input ADDR_W: byte address of the store.
- `wdata` input 32: register data. SB uses [7:0], SH uses [15:0], SW uses all 32 bits.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `misalign` output 1: fault flag, valid while `done` is high.
- `mem_addr` output ADDR_W: word-aligned address, `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_rd` output 1: memory read request.
- `mem_wr` output 1: memory write request.
- `mem_wdata` output 32: merged write word.
- `mem_rdata` input 32: read data; valid in the cycle `mem_ready` is high during RD.
- `mem_ready` input 1: memory accepts or completes the current request in this cycle.

## Operation
- States: IDLE, RD, WR, DONE. State is a registered FSM; all outputs are registered or decoded from state.
- IDLE with `start`=1:
  - Latch `op`, `addr`, `wdata`.
  - Fault check: SH with addr[0]=1, SW with addr[1:0]≠0, or op=11. On a fault, go to DONE with `misalign`=1 and issue no memory access.
  - Otherwise SW goes to WR; SB and SH go to RD.
- IDLE with `start`=0: stay in IDLE.
- RD:
  - `mem_rd`=1, `mem_addr` held.
  - Stay in RD while `mem_ready`=0.
  - On `mem_ready`=1, capture `mem_rdata`, merge, and go to WR.
- Merge, little-endian lanes:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces halfword lane addr[1] with wdata[15:0].
  - All other bits are copied from the captured `mem_rdata`.
  - SW: `mem_wdata` = wdata.
- WR:
  - `mem_wr`=1; `mem_wdata` and `mem_addr` stable for the whole state.
  - Stay in WR while `mem_ready`=0.
  - On `mem_ready`=1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` asserted while `busy`=1 is ignored, not queued.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `mem_ready` outside RD/WR is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `misalign`, `mem_rd` and `mem_wr` all 0; `mem_addr` and `mem_wdata` 0.
- Reset mid-operation (any state): the next edge forces IDLE, and all request outputs are 0 from that edge. No partial write completes after reset.
- `start` is sampled at edge k. The first state after IDLE is active from edge k, so `busy` rises from edge k.
- Latency with zero wait states, counted from the start edge to the edge that asserts `done`:
  - SW: 2 edges (WR, then DONE).
  - SB/SH: 3 edges (RD, WR, DONE).
  - Fault: 1 edge (straight to DONE).
- Each cycle with `mem_ready`=0 in RD or WR adds one cycle of latency.
- `misalign` is asserted only together with `done`, and is 0 on successful completions.
- Back-to-back operation: a new `start` is accepted in the IDLE cycle immediately after DONE. Minimum issue interval is 3 cycles for SW and 4 cycles for SB/SH.

## Test plan
- SW, addr=0x10, wdata=0xDEADBEEF, `mem_ready` tied 1:
  - One `mem_wr` cycle with `mem_addr`=0x10 and `mem_wdata`=0xDEADBEEF.
  - No `mem_rd`.
  - `done` two edges after start, `misalign`=0.
- SB, addr=0x23, wdata=0x000000AB, `mem_rdata`=0x11223344:
  - One `mem_rd` cycle at 0x20, then `mem_wdata`=0xAB223344.
  - `done` three edges after start.
- SH, addr=0x06, wdata=0xFFFFCAFE, `mem_rdata`=0x11223344, with two `mem_ready`=0 cycles in RD and one in WR:
  - `mem_wdata`=0xCAFE3344 at `mem_addr`=0x04.
  - `done` six edges after start.
- Faults, one case each:
  - SH addr=0x01; SW addr=0x02; op=11.
  - Each must produce no `mem_rd`/`mem_wr`, `done` with `misalign`=1 one edge after start, and `busy` back to 0 the cycle after.
- Reset and ignored start:
  - Assert `rst` while in WR with `mem_ready`=0: `mem_wr` is 0 from the next edge, state is IDLE, and no `done` is produced.
  - A `start` pulsed while `busy`=1 produces no second transaction.
